output_arbiter: RTL

OUTPUT_ARBITER -- requirements
Module: output_arbiter

---
 rtl/arb_pkg.sv | 35 +++
 rtl/output_arbiter_rr_picker.sv | 30 +++
 rtl/output_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the three-requester output arbiter.
package arb_pkg;

    localparam int NumReq = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    typedef logic [1:0] req_idx_t;

    function automatic req_idx_t next_idx(input req_idx_t idx);
        req_idx_t nxt;
        if (idx >= req_idx_t'(NumReq - 1)) begin
            nxt = '0;
        end else begin
            nxt = idx + 2'd1;
        end
        return nxt;
    endfunction

    function automatic req_idx_t onehot_to_idx(input logic [NumReq-1:0] oh);
        req_idx_t idx;
        idx = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (oh[i]) begin
                idx = req_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/output_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request scanning upward from ptr, wrapping.
module rr_picker
    import arb_pkg::*;
(
    input  logic [NumReq-1:0] req,
    input  req_idx_t          ptr,
    output logic [NumReq-1:0] winner,
    output logic              valid
);

    always_comb begin
        int base;
        int j;
        winner = '0;
        valid  = 1'b0;
        base   = (int'(ptr) >= NumReq) ? 0 : int'(ptr);
        j      = 0;
        for (int i = 0; i < NumReq; i++) begin
            j = base + i;
            if (j >= NumReq) begin
                j = j - NumReq;
            end
            if (!valid && req[j]) begin
                winner[j] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_arbiter.sv
// Three-requester arbiter with minimum hold and registered grant/data outputs.
// Define ARB_TIMEOUT_EN to revoke a grant that reaches TimeoutCycles while others wait.
//
// state   | meaning
// IDLE    | no owner; arbitrates on any request
// GRANT   | owner holds gnt_o, d_o follows its data bit, hold counter runs
// RELEASE | one-cycle gap with gnt_o=0; ptr advances past the old owner
module output_arbiter
    import arb_pkg::*;
#(
    parameter int HoldCycles    = 8,
    parameter int TimeoutCycles = 64
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [NumReq-1:0] req_i,
    input  logic [NumReq-1:0] data_i,
    output logic [NumReq-1:0] gnt_o,
    output logic              d_o,
    output logic              busy_o
);

    localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CntW-1:0] CntMax   = CntW'(TimeoutCycles - 1);
    localparam logic [CntW-1:0] HoldLast = CntW'(HoldCycles - 1);

    arb_state_e        state_q, state_d;
    req_idx_t          owner_q, owner_d;
    req_idx_t          ptr_q, ptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [NumReq-1:0] gnt_q, gnt_d;
    logic              d_q, d_d;
    logic              busy_q, busy_d;

    req_idx_t          pick_ptr;
    logic [NumReq-1:0] pick_winner;
    logic              pick_valid;
    logic              timeout_hit;

    // The exit edge of RELEASE arbitrates with the already-advanced pointer,
    // so a waiting requester sees only the single RELEASE cycle as a gap.
    assign pick_ptr = (state_q == RELEASE) ? next_idx(owner_q) : ptr_q;

    rr_picker u_picker (
        .req    (req_i),
        .ptr    (pick_ptr),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

`ifdef ARB_TIMEOUT_EN
    logic others_req;
    assign others_req  = |(req_i & ~gnt_q);
    assign timeout_hit = (cnt_q == CntMax) && others_req;
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        d_d     = d_q;
        busy_d  = busy_q;

        case (state_q)
            IDLE, RELEASE: begin
                if (state_q == RELEASE) begin
                    ptr_d = next_idx(owner_q);
                end
                cnt_d = '0;
                if (pick_valid) begin
                    state_d = GRANT;
                    owner_d = onehot_to_idx(pick_winner);
                    gnt_d   = pick_winner;
                    d_d     = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    d_d     = 1'b0;
                    busy_d  = 1'b0;
                end
            end

            GRANT: begin
                if ((!req_i[owner_q] && (cnt_q >= HoldLast)) || timeout_hit) begin
                    state_d = RELEASE;
                    gnt_d   = '0;
                    d_d     = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    d_d    = data_i[owner_q];
                    busy_d = 1'b1;
                    if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                d_d     = 1'b0;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            d_q     <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            d_q     <= d_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt_o  = gnt_q;
    assign d_o    = d_q;
    assign busy_o = busy_q;

endmodule
